// File: rtl/snitch_icache_pkg.sv
`timescale 1ns/1ps
// Shared icache definitions: flush sequencer state encoding and limits.
// Imported by every icache block and bench that needs them.
package snitch_icache_pkg;

    localparam int unsigned MAX_FETCH_PORTS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FL_L1 = 2'd1,
        FL_L0 = 2'd2,
        ACK   = 2'd3
    } icache_flush_seq_state_e;

endpackage

// File: rtl/cluster_icache_flush_seq_if.sv
`timescale 1ns/1ps
// Handshake bundle around the icache flush sequencer.
// Ports: requester side (l0/l1 req valid/ready), cache side
// (l1/l0 flush valid/ready) and busy. Directions are named from the
// sequencer's view; slave = sequencer, master = its environment.
interface cluster_icache_flush_seq_if #(
    parameter int unsigned NR_FETCH_PORTS = 4
);
    logic [NR_FETCH_PORTS-1:0] l0_req_valid_i;
    logic [NR_FETCH_PORTS-1:0] l0_req_ready_o;
    logic                      l1_req_valid_i;
    logic                      l1_req_ready_o;
    logic                      l1_flush_valid_o;
    logic                      l1_flush_ready_i;
    logic [NR_FETCH_PORTS-1:0] l0_flush_valid_o;
    logic [NR_FETCH_PORTS-1:0] l0_flush_ready_i;
    logic                      busy_o;

    modport master (
        output l0_req_valid_i,
        input  l0_req_ready_o,
        output l1_req_valid_i,
        input  l1_req_ready_o,
        input  l1_flush_valid_o,
        output l1_flush_ready_i,
        input  l0_flush_valid_o,
        output l0_flush_ready_i,
        input  busy_o
    );

    modport slave (
        input  l0_req_valid_i,
        output l0_req_ready_o,
        input  l1_req_valid_i,
        output l1_req_ready_o,
        output l1_flush_valid_o,
        input  l1_flush_ready_i,
        output l0_flush_valid_o,
        input  l0_flush_ready_i,
        output busy_o
    );

endinterface

// File: rtl/cluster_icache_flush_seq.sv
`timescale 1ns/1ps
// Icache flush sequencer: merges L0/global flush requests into one pass,
// flushes L1 before any L0, then pulses acks to captured requesters.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport).
module cluster_icache_flush_seq
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cluster_icache_flush_seq_if.slave    bus
);

    localparam int unsigned N = NR_FETCH_PORTS;

    icache_flush_seq_state_e r_state;
    icache_flush_seq_state_e w_state_d;

    logic         r_pend_l1;
    logic         w_pend_l1_d;
    logic [N-1:0] r_pend_l0;
    logic [N-1:0] w_pend_l0_d;
    logic [N-1:0] r_done_l0;
    logic [N-1:0] w_done_l0_d;
    logic [N-1:0] r_ack_l0;
    logic [N-1:0] w_ack_l0_d;

    logic [N-1:0] w_l0_valid;
    logic [N-1:0] w_l0_hs;
    logic [N-1:0] w_done_now;

    // All outputs come from registered state only.
    assign w_l0_valid = (r_state == FL_L0) ? (r_pend_l0 & ~r_done_l0)
                                           : '0;
    // Ready without a matching valid is masked off here.
    assign w_l0_hs    = w_l0_valid & bus.l0_flush_ready_i;
    assign w_done_now = r_done_l0 | w_l0_hs;

    assign bus.l1_flush_valid_o = (r_state == FL_L1);
    assign bus.l0_flush_valid_o = w_l0_valid;
    assign bus.l0_req_ready_o   = (r_state == ACK) ? r_ack_l0 : '0;
    assign bus.l1_req_ready_o   = (r_state == ACK) && r_pend_l1;
    assign bus.busy_o           = (r_state != IDLE);

    always_comb begin
        w_state_d   = r_state;
        w_pend_l1_d = r_pend_l1;
        w_pend_l0_d = r_pend_l0;
        w_done_l0_d = r_done_l0;
        w_ack_l0_d  = r_ack_l0;
        unique case (r_state)
            IDLE: begin
                if (bus.l1_req_valid_i) begin
                    // Global flush hits every L0, acks only requesters.
                    w_pend_l1_d = 1'b1;
                    w_pend_l0_d = '1;
                    w_ack_l0_d  = bus.l0_req_valid_i;
                    w_done_l0_d = '0;
                    w_state_d   = FL_L1;
                end else if (|bus.l0_req_valid_i) begin
                    w_pend_l0_d = bus.l0_req_valid_i;
                    w_ack_l0_d  = bus.l0_req_valid_i;
                    w_done_l0_d = '0;
                    w_state_d   = FL_L0;
                end
            end
            FL_L1: begin
                if (bus.l1_flush_ready_i) begin
                    w_state_d = FL_L0;
                end
            end
            FL_L0: begin
                w_done_l0_d = w_done_now;
                if (w_done_now == r_pend_l0) begin
                    w_state_d = ACK;
                end
            end
            ACK: begin
                w_pend_l1_d = 1'b0;
                w_pend_l0_d = '0;
                w_ack_l0_d  = '0;
                w_state_d   = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_pend_l1 <= 1'b0;
            r_pend_l0 <= '0;
            r_done_l0 <= '0;
            r_ack_l0  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_pend_l1 <= w_pend_l1_d;
            r_pend_l0 <= w_pend_l0_d;
            r_done_l0 <= w_done_l0_d;
            r_ack_l0  <= w_ack_l0_d;
        end
    end

endmodule

// File: tb/tb_cluster_icache_flush_seq.sv
`timescale 1ns/1ps
// Directed bench for cluster_icache_flush_seq with N=4.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_cluster_icache_flush_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    cluster_icache_flush_seq_if #(.NR_FETCH_PORTS(4)) bus ();

    cluster_icache_flush_seq #(.NR_FETCH_PORTS(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l1v,
                           input logic [3:0] l0v, input logic l1a,
                           input logic [3:0] l0a, input logic bsy);
        chk({tag, ".l1_flush_valid"}, 32'(bus.l1_flush_valid_o), 32'(l1v));
        chk({tag, ".l0_flush_valid"}, 32'(bus.l0_flush_valid_o), 32'(l0v));
        chk({tag, ".l1_req_ready"}, 32'(bus.l1_req_ready_o), 32'(l1a));
        chk({tag, ".l0_req_ready"}, 32'(bus.l0_req_ready_o), 32'(l0a));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(bsy));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.l0_req_valid_i   = 4'b0000;
        bus.l1_req_valid_i   = 1'b0;
        bus.l1_flush_ready_i = 1'b0;
        bus.l0_flush_ready_i = 4'b0000;
        #12;
        chk_all("reset", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Spurious downstream ready in IDLE
        bus.l0_flush_ready_i = 4'b1111;
        bus.l1_flush_ready_i = 1'b1;
        step();
        chk_all("spur1", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        step();
        chk_all("spur2", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        bus.l0_flush_ready_i = 4'b0000;
        bus.l1_flush_ready_i = 1'b0;

        // Single port 2, ready 3 cycles after valid
        bus.l0_req_valid_i = 4'b0100;
        step();
        chk_all("single.c1", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        step();
        chk_all("single.c2", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        step();
        chk_all("single.c3", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0100;
        step();
        chk_all("single.ack", 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        chk_all("single.post", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        bus.l0_req_valid_i = 4'b0000;
        step();
        chk_all("single.idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Global plus port 0 in the same cycle
        bus.l1_req_valid_i = 1'b1;
        bus.l0_req_valid_i = 4'b0001;
        step();
        chk_all("glob.l1a", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        step();
        chk_all("glob.l1b", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        bus.l1_flush_ready_i = 1'b1;
        step();
        chk_all("glob.l0", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1);
        bus.l1_flush_ready_i = 1'b0;
        bus.l0_flush_ready_i = 4'b1111;
        step();
        chk_all("glob.ack", 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        chk_all("glob.post", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        bus.l1_req_valid_i = 1'b0;
        bus.l0_req_valid_i = 4'b0000;
        step();
        chk_all("glob.idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Staggered readies: pend 1011, ports 0, 3, 1
        bus.l0_req_valid_i = 4'b1011;
        step();
        chk_all("stag.c1", 1'b0, 4'b1011, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0001;
        step();
        chk_all("stag.c2", 1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b1000;
        step();
        chk_all("stag.c3", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0010;
        step();
        chk_all("stag.ack", 1'b0, 4'b0000, 1'b0, 4'b1011, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        chk_all("stag.post", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        bus.l0_req_valid_i = 4'b0000;
        step();

        // Late request from port 2 during port 0's pass
        bus.l0_req_valid_i = 4'b0001;
        step();
        chk_all("late.c1", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1);
        bus.l0_req_valid_i = 4'b0101;
        step();
        chk_all("late.c2", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0001;
        step();
        chk_all("late.ack0", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        chk_all("late.idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        bus.l0_req_valid_i = 4'b0100;
        step();
        chk_all("late.fl2", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0100;
        step();
        chk_all("late.ack2", 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        bus.l0_req_valid_i = 4'b0000;
        step();
        chk_all("late.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Reset asserted during FL_L1, request held across it
        bus.l1_req_valid_i = 1'b1;
        step();
        chk_all("rst.fl1", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        step();
        chk_all("rst.held", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("rst.re_l1", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1);
        bus.l1_flush_ready_i = 1'b1;
        step();
        chk_all("rst.re_l0", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1);
        bus.l1_flush_ready_i = 1'b0;
        bus.l0_flush_ready_i = 4'b1111;
        step();
        chk_all("rst.ack", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        bus.l0_flush_ready_i = 4'b0000;
        step();
        bus.l1_req_valid_i = 1'b0;
        step();
        chk_all("rst.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cluster_icache_flush_seq.md
# cluster_icache_flush_seq

Flush sequencer between the icache control-register block and the L0/L1 icache datapaths. It collects per-fetch-port L0 flush requests and global (L1 + all L0) flush requests. It orders them so the L1 is always invalidated before any L0. It holds a completion acknowledge back to each requester and merges requests that arrive together into one flush pass.

## Interface
Parameters:
- NR_FETCH_PORTS, default 4: number of L0 caches / fetch ports, 1..32.

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- l0_req_valid_i  in  NR_FETCH_PORTS  per-port L0 flush request. Held until acked.
- l0_req_ready_o  out  NR_FETCH_PORTS  per-port completion ack, one-cycle pulse.
- l1_req_valid_i  in  1  global flush request (L1 plus all L0s). Held until acked.
- l1_req_ready_o  out  1  global completion ack, one-cycle pulse.
- l1_flush_valid_o  out  1  flush command to the L1.
- l1_flush_ready_i  in  1  L1 flush done. Transfer on valid & ready.
- l0_flush_valid_o  out  NR_FETCH_PORTS  flush command to each L0.
- l0_flush_ready_i  in  NR_FETCH_PORTS  per-L0 flush done.
- busy_o  out  1  high whenever state ≠ IDLE.

## Operation
State register values: IDLE, FL_L1, FL_L0, ACK. Registered state also includes:
- pend_l1 (1 bit)
- pend_l0 (NR_FETCH_PORTS bits)
- done_l0 (NR_FETCH_PORTS bits)

IDLE:
- If l1_req_valid_i is high:
  - pend_l1 <= 1
  - pend_l0 <= all ones
  - ack_l0 <= l0_req_valid_i
  - next state FL_L1
- Else if |l0_req_valid_i:
  - pend_l0 <= l0_req_valid_i
  - ack_l0 <= l0_req_valid_i
  - next state FL_L0
- Else stay in IDLE.
- done_l0 is cleared on every capture.

FL_L1:
- l1_flush_valid_o = 1.
- On l1_flush_ready_i, go to FL_L0.

FL_L0:
- l0_flush_valid_o = pend_l0 & ~done_l0.
- Each bit with valid & ready sets its done_l0 bit.
- When (done_l0 | (l0_flush_valid_o & l0_flush_ready_i)) == pend_l0, go to ACK.

ACK, one cycle:
- l0_req_ready_o = ack_l0.
- l1_req_ready_o = pend_l1.
- Clear pend_l1, pend_l0 and ack_l0; return to IDLE.

Further rules:
- Only requests captured in IDLE are acked. A port whose request was not captured gets no ack; its request is served in a later pass.
- Requests that rise while the block is busy wait in their requester. They are captured in the first IDLE cycle after ACK.
- Downstream ready while the matching valid is low is ignored.
- A global request issues an L0 flush to every port, not only the requesting ones. Only the ports captured in ack_l0 plus the L1 requester are acked.
- Requester protocol: valid stays high until its ready pulse and drops the cycle after. Dropping valid early is illegal; the block still completes and acks.

## Timing
- Reset value of every output and register is 0; state is IDLE.
- Reset asserted mid-flush aborts immediately: all valids drop, pending state is lost, no ack is issued.
- All outputs are decoded from registered state only. No combinational path exists from any input to any valid or ack output.
- Minimum latency, L0-only request:
  - Request seen at cycle 0.
  - l0_flush_valid_o high at cycle 1.
  - If ready arrives at cycle 1, ACK at cycle 2.
- Minimum latency, global request:
  - L1 valid at cycle 1; L1 ready at cycle 1.
  - L0 valids at cycle 2; L0 readies at cycle 2.
  - ACK at cycle 3.
- Back-to-back passes: the earliest next capture is the cycle after ACK.
- Per-port L0 flushes run in parallel. Completion order between ports is arbitrary.

## Structure
- State enum `icache_flush_seq_state_e` (IDLE, FL_L1, FL_L0, ACK) goes in `snitch_icache_pkg`. All icache blocks and benches share it.
- No sub-module; the block is one FSM with mask registers.
- Integration: the control unit's flush_valid_o drives l0_req_valid_i. Its global flush drives l1_req_valid_i.

## Test plan
- **Single port:** N=4, l0_req_valid_i=0b0100, L0 ready returned 3 cycles after its valid.
  - l0_flush_valid_o=0b0100 for 3 cycles.
  - l0_req_ready_o=0b0100 pulses exactly once.
  - l1_flush_valid_o is never high.
- **Global with concurrent port request:** l1_req_valid_i=1 and l0_req_valid_i=0b0001 in the same cycle.
  - L1 valid is high first; no L0 valid until the L1 handshake.
  - Then l0_flush_valid_o=0b1111.
  - Ack: l1_req_ready_o=1 and l0_req_ready_o=0b0001 in the same cycle.
- **Staggered L0 readies:** pend=0b1011, readies for ports 0, 3, 1 on consecutive cycles.
  - Each valid bit drops after its own handshake.
  - ACK the cycle after port 1's ready.
- **Late request:** port 2 raises its request during FL_L0 of a pass for port 0.
  - No ack to port 2 in that pass.
  - Port 2 is captured in the IDLE after ACK; its ack arrives 2 cycles later when readies are immediate.
- **Reset mid-flush:** rst_ni asserted during FL_L1.
  - All outputs 0 asynchronously; state returns to IDLE.
  - After release, a held request restarts with a full flush sequence.
- **Spurious ready:** l0_flush_ready_i=0b1111 while in IDLE.
  - No state change, no ack.
